// File: rtl/lcd_cfah_ctrl_if.sv
// Host request/response and LCD pad signals for lcd_cfah_ctrl.
// The controller connects through the slave modport; the host/top level uses master.
interface lcd_cfah_ctrl_if;
    logic       i_start;
    logic       i_rs;
    logic       i_rnw;
    logic [7:0] i_wdata;
    logic       i_poll_bf;
    logic [7:0] o_rdata;
    logic       o_done;
    logic       o_busy;
    logic       o_timeout;
    logic       o_lcd_rs;
    logic       o_lcd_rw;
    logic       o_lcd_en;
    logic [7:0] o_lcd_data;
    logic       o_lcd_data_oe;
    logic [7:0] i_lcd_data;

    modport slave (
        input  i_start, i_rs, i_rnw, i_wdata, i_poll_bf, i_lcd_data,
        output o_rdata, o_done, o_busy, o_timeout,
        output o_lcd_rs, o_lcd_rw, o_lcd_en, o_lcd_data, o_lcd_data_oe
    );

    modport master (
        output i_start, i_rs, i_rnw, i_wdata, i_poll_bf, i_lcd_data,
        input  o_rdata, o_done, o_busy, o_timeout,
        input  o_lcd_rs, o_lcd_rw, o_lcd_en, o_lcd_data, o_lcd_data_oe
    );
endinterface

// File: rtl/lcd_cfah_ctrl.sv
// Character-LCD bus access controller: one timed read/write cycle per start,
// optionally followed by busy-flag polling until clear or until the poll limit.
module lcd_cfah_ctrl #(
    parameter int unsigned G_T_SETUP  = 2,
    parameter int unsigned G_T_PULSE  = 12,
    parameter int unsigned G_T_HOLD   = 2,
    parameter int unsigned G_POLL_MAX = 255
) (
    input  logic              clk,
    input  logic              rst,
    lcd_cfah_ctrl_if.slave    bus
);

    localparam int unsigned PH_MAX =
        (G_T_SETUP > G_T_PULSE) ? ((G_T_SETUP > G_T_HOLD) ? G_T_SETUP : G_T_HOLD)
                                : ((G_T_PULSE > G_T_HOLD) ? G_T_PULSE : G_T_HOLD);
    // Phase counter runs 0..PH_MAX-1; poll counter runs 0..G_POLL_MAX.
    localparam int unsigned PH_W = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;
    localparam int unsigned PC_W = (G_POLL_MAX > 1) ? $clog2(G_POLL_MAX + 1) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_PULSE,
        S_HOLD,
        S_CHECK,
        S_DONE
    } state_t;

    state_t          state, state_nxt;
    logic [PH_W-1:0] ph_cnt;
    logic [PC_W-1:0] poll_cnt;
    logic            acc_rs, acc_rnw, acc_poll;
    logic [7:0]      acc_wdata;
    logic            in_poll;
    logic            bf_flag;
    logic [7:0]      rdata_q;
    logic            timeout_q;
    logic            ph_end, accept, set_timeout;
    logic            active, cur_rs, cur_rnw;

    always_comb begin
        ph_end      = 1'b0;
        accept      = 1'b0;
        set_timeout = 1'b0;
        state_nxt   = state;
        case (state)
            S_SETUP: ph_end = (ph_cnt == PH_W'(G_T_SETUP - 1));
            S_PULSE: ph_end = (ph_cnt == PH_W'(G_T_PULSE - 1));
            S_HOLD:  ph_end = (ph_cnt == PH_W'(G_T_HOLD - 1));
            default: ph_end = 1'b0;
        endcase
        case (state)
            S_IDLE: begin
                if (bus.i_start) begin
                    accept    = 1'b1;
                    state_nxt = S_SETUP;
                end
            end
            S_SETUP: if (ph_end) state_nxt = S_PULSE;
            S_PULSE: if (ph_end) state_nxt = S_HOLD;
            S_HOLD: begin
                if (ph_end) begin
                    if (in_poll)       state_nxt = S_CHECK;
                    else if (acc_poll) state_nxt = S_SETUP;
                    else               state_nxt = S_DONE;
                end
            end
            S_CHECK: begin
                if (!bf_flag) begin
                    state_nxt = S_DONE;
                end else if (poll_cnt == PC_W'(G_POLL_MAX)) begin
                    state_nxt   = S_DONE;
                    set_timeout = 1'b1;
                end else begin
                    state_nxt = S_SETUP;
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Restarts on every state change, so HOLD->SETUP and CHECK->SETUP begin a fresh phase.
    always_ff @(posedge clk) begin
        if (rst || (state_nxt != state) || !active) ph_cnt <= '0;
        else                                        ph_cnt <= ph_cnt + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_rs    <= 1'b0;
            acc_rnw   <= 1'b0;
            acc_poll  <= 1'b0;
            acc_wdata <= '0;
            in_poll   <= 1'b0;
            bf_flag   <= 1'b0;
            rdata_q   <= '0;
            timeout_q <= 1'b0;
            poll_cnt  <= '0;
        end else begin
            if (accept) begin
                acc_rs    <= bus.i_rs;
                acc_rnw   <= bus.i_rnw;
                acc_poll  <= bus.i_poll_bf;
                acc_wdata <= bus.i_wdata;
                in_poll   <= 1'b0;
                timeout_q <= 1'b0;
                poll_cnt  <= '0;
            end
            // Poll reads only feed the busy-flag check; o_rdata belongs to the main access.
            if (state == S_PULSE && ph_end) begin
                if (in_poll)      bf_flag <= bus.i_lcd_data[7];
                else if (acc_rnw) rdata_q <= bus.i_lcd_data;
            end
            if (state == S_HOLD && ph_end) begin
                if (in_poll) begin
                    if (poll_cnt != PC_W'(G_POLL_MAX)) poll_cnt <= poll_cnt + 1'b1;
                end else if (acc_poll) begin
                    in_poll <= 1'b1;
                end
            end
            if (set_timeout) timeout_q <= 1'b1;
        end
    end

    assign active  = (state == S_SETUP) || (state == S_PULSE) || (state == S_HOLD);
    assign cur_rs  = in_poll ? 1'b0 : acc_rs;
    assign cur_rnw = in_poll ? 1'b1 : acc_rnw;

    assign bus.o_lcd_rs      = active & cur_rs;
    assign bus.o_lcd_rw      = active & cur_rnw;
    assign bus.o_lcd_en      = (state == S_PULSE);
    assign bus.o_lcd_data_oe = active & ~cur_rnw;
    assign bus.o_lcd_data    = (active && !cur_rnw) ? acc_wdata : '0;
    assign bus.o_busy        = (state != S_IDLE);
    assign bus.o_done        = (state == S_DONE);
    assign bus.o_rdata       = rdata_q;
    assign bus.o_timeout     = timeout_q;

endmodule
